// File: rtl/snn_lif_accumulator.sv
// Leaky-integrate-and-fire accumulator: collects NUM_PE partial sums plus a membrane
// potential, produces a saturated, thresholded update. Optional leak via SNN_LIF_LEAK_EN.
module snn_lif_accumulator #(
    parameter int unsigned NUM_PE     = 3,
    parameter int unsigned IN_WIDTH   = 5,
    parameter int unsigned MEM_WIDTH  = 8,
    parameter int unsigned LEAK_SHIFT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PE*IN_WIDTH-1:0]   pe_data,
    input  logic [NUM_PE-1:0]            pe_valid,
    output logic [NUM_PE-1:0]            pe_ready,
    input  logic [MEM_WIDTH-1:0]         mem_in,
    input  logic                         mem_in_valid,
    output logic                         mem_in_ready,
    input  logic [MEM_WIDTH-1:0]         threshold,
    input  logic                         reset_mode,
    output logic [MEM_WIDTH-1:0]         mem_out,
    output logic                         spike_out,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int unsigned SUM_W = MEM_WIDTH + 4;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [IN_WIDTH-1:0]    r_pe_slot [NUM_PE];
    logic [NUM_PE-1:0]      r_pe_full;
    logic [MEM_WIDTH-1:0]   r_mem_slot;
    logic                   r_mem_full;

    logic                   w_collect;
    logic [NUM_PE-1:0]      w_pe_take;
    logic                   w_mem_take;
    logic                   w_all_full;
    logic [MEM_WIDTH-1:0]   w_m;
    logic [SUM_W-1:0]       w_raw;
    logic [MEM_WIDTH-1:0]   w_sat;
    logic                   w_spike;
    logic [MEM_WIDTH-1:0]   w_mem_next;

    // Readies come only from registered state and flags, never from a valid.
    assign w_collect    = (r_state == S_COLLECT);
    assign pe_ready     = w_collect ? ~r_pe_full : '0;
    assign mem_in_ready = w_collect & ~r_mem_full;
    assign w_pe_take    = pe_valid & pe_ready;
    assign w_mem_take   = mem_in_valid & mem_in_ready;
    assign w_all_full   = (&r_pe_full) & r_mem_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_COLLECT: if (w_all_full) w_next_state = S_COMPUTE;
            S_COMPUTE: w_next_state = S_OUTPUT;
            S_OUTPUT:  if (out_ready) w_next_state = S_COLLECT;
            default:   w_next_state = S_COLLECT;
        endcase
    end

    // Input slots; flags drop together once the update has been computed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pe_full  <= '0;
            r_mem_full <= 1'b0;
            r_mem_slot <= '0;
            for (int i = 0; i < int'(NUM_PE); i++) begin
                r_pe_slot[i] <= '0;
            end
        end else if (r_state == S_COMPUTE) begin
            r_pe_full  <= '0;
            r_mem_full <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_PE); i++) begin
                if (w_pe_take[i]) begin
                    r_pe_slot[i] <= pe_data[i*IN_WIDTH +: IN_WIDTH];
                    r_pe_full[i] <= 1'b1;
                end
            end
            if (w_mem_take) begin
                r_mem_slot <= mem_in;
                r_mem_full <= 1'b1;
            end
        end
    end

`ifdef SNN_LIF_LEAK_EN
    assign w_m = r_mem_slot - (r_mem_slot >> LEAK_SHIFT);
`else
    logic [31:0] w_unused_leak;
    assign w_unused_leak = 32'(LEAK_SHIFT);
    assign w_m = r_mem_slot;
`endif

    // Wide sum cannot wrap; saturate back to the membrane range before thresholding.
    always_comb begin
        w_raw = SUM_W'(w_m);
        for (int i = 0; i < int'(NUM_PE); i++) begin
            w_raw = w_raw + SUM_W'(r_pe_slot[i]);
        end
    end

    assign w_sat      = (w_raw > SUM_W'({MEM_WIDTH{1'b1}})) ? {MEM_WIDTH{1'b1}}
                                                            : MEM_WIDTH'(w_raw);
    assign w_spike    = (w_sat >= threshold);
    assign w_mem_next = !w_spike   ? w_sat :
                        reset_mode ? MEM_WIDTH'(w_sat - threshold) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_out   <= '0;
            spike_out <= 1'b0;
            out_valid <= 1'b0;
        end else if (r_state == S_COMPUTE) begin
            mem_out   <= w_mem_next;
            spike_out <= w_spike;
            out_valid <= 1'b1;
        end else if (r_state == S_OUTPUT && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snn_lif_accumulator.sv
// Directed self-checking bench for snn_lif_accumulator (NUM_PE=3, IN_WIDTH=5, MEM_WIDTH=8).
module tb_snn_lif_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] pe_data;
    logic [2:0]  pe_valid;
    logic [2:0]  pe_ready;
    logic [7:0]  mem_in;
    logic        mem_in_valid;
    logic        mem_in_ready;
    logic [7:0]  threshold;
    logic        reset_mode;
    logic [7:0]  mem_out;
    logic        spike_out;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    snn_lif_accumulator #(
        .NUM_PE(3), .IN_WIDTH(5), .MEM_WIDTH(8), .LEAK_SHIFT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pe_data(pe_data), .pe_valid(pe_valid), .pe_ready(pe_ready),
        .mem_in(mem_in), .mem_in_valid(mem_in_valid), .mem_in_ready(mem_in_ready),
        .threshold(threshold), .reset_mode(reset_mode),
        .mem_out(mem_out), .spike_out(spike_out),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All inputs on one edge, out_ready held high; checks latency and result.
    task automatic txn(input int p0, input int p1, input int p2, input int m,
                       input int thr, input logic mode,
                       input int exp_mem, input int exp_spk, input string tag);
        pe_data      = {5'(p2), 5'(p1), 5'(p0)};
        pe_valid     = 3'b111;
        mem_in       = 8'(m);
        mem_in_valid = 1'b1;
        threshold    = 8'(thr);
        reset_mode   = mode;
        step();
        pe_valid     = 3'b000;
        mem_in_valid = 1'b0;
        chk({tag, "_valid_n"}, int'(out_valid), 0);
        step();
        chk({tag, "_valid_n1"}, int'(out_valid), 0);
        step();
        chk({tag, "_valid_n2"}, int'(out_valid), 1);
        chk({tag, "_mem"}, int'(mem_out), exp_mem);
        chk({tag, "_spike"}, int'(spike_out), exp_spk);
        step();
        chk({tag, "_valid_done"}, int'(out_valid), 0);
        chk({tag, "_ready_back"}, int'({pe_ready, mem_in_ready}), 15);
    endtask

    initial begin
        rst_n        = 1'b0;
        pe_data      = '0;
        pe_valid     = '0;
        mem_in       = '0;
        mem_in_valid = 1'b0;
        threshold    = 8'd200;
        reset_mode   = 1'b0;
        out_ready    = 1'b1;
        #2;
        chk("rst_pe_ready", int'(pe_ready), 7);
        chk("rst_mem_ready", int'(mem_in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_mem_out", int'(mem_out), 0);
        chk("rst_spike", int'(spike_out), 0);
        step();
        rst_n = 1'b1;
        step();

        txn(10, 20, 30, 50, 200, 1'b0, 110, 0, "basic");
        txn(31, 31, 31, 150, 200, 1'b0, 0, 1, "spike_m0");
        txn(31, 31, 31, 150, 200, 1'b1, 43, 1, "spike_m1");
        txn(31, 31, 31, 250, 255, 1'b1, 0, 1, "sat_m1");
        txn(31, 31, 31, 250, 0, 1'b0, 0, 1, "sat_thr0");

        // Out-of-order arrival: 5+6+7+20 = 38 >= 30, subtract -> 8
        out_ready    = 1'b0;
        threshold    = 8'd30;
        reset_mode   = 1'b1;
        mem_in       = 8'd20;
        mem_in_valid = 1'b1;
        step();
        mem_in_valid = 1'b0;
        chk("ooo_mem_ready", int'(mem_in_ready), 0);
        chk("ooo_pe_ready0", int'(pe_ready), 7);
        pe_data  = {5'd7, 5'd0, 5'd0};
        pe_valid = 3'b100;
        step();
        pe_data  = {5'd0, 5'd0, 5'd5};
        pe_valid = 3'b001;
        step();
        chk("ooo_pe_ready1", int'(pe_ready), 2);
        pe_data  = {5'd0, 5'd6, 5'd0};
        pe_valid = 3'b010;
        step();
        pe_valid = 3'b000;
        step();
        chk("ooo_valid_n1", int'(out_valid), 0);
        step();
        chk("ooo_mem", int'(mem_out), 8);
        chk("ooo_spike", int'(spike_out), 1);
        // Backpressure with a pending PE0 valid that must not be consumed.
        pe_data  = {5'd0, 5'd0, 5'd9};
        pe_valid = 3'b001;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_mem", int'(mem_out), 8);
            chk("bp_spike", int'(spike_out), 1);
            chk("bp_readies", int'({pe_ready, mem_in_ready}), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_pe0_ready", int'(pe_ready[0]), 1);
        step();
        pe_valid = 3'b000;
        chk("bp_pe0_taken", int'(pe_ready), 6);
        // Complete it: 9 + 1 + 1 + 0 = 11 < 30
        pe_data      = {5'd1, 5'd1, 5'd0};
        pe_valid     = 3'b110;
        mem_in       = 8'd0;
        mem_in_valid = 1'b1;
        step();
        pe_valid     = 3'b000;
        mem_in_valid = 1'b0;
        step();
        step();
        chk("bp_next_valid", int'(out_valid), 1);
        chk("bp_next_mem", int'(mem_out), 11);
        chk("bp_next_spike", int'(spike_out), 0);
        step();

        // Reset mid-collect discards captured PE0/PE1.
        pe_data  = {5'd0, 5'd2, 5'd1};
        pe_valid = 3'b011;
        step();
        pe_valid = 3'b000;
        chk("mid_pe_ready", int'(pe_ready), 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pe_ready", int'(pe_ready), 7);
        chk("mid_rst_mem_ready", int'(mem_in_ready), 1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        step();
        rst_n = 1'b1;
        step();
        txn(1, 2, 3, 4, 200, 1'b0, 10, 0, "after_rst");

`ifdef SNN_LIF_LEAK_EN
        txn(0, 0, 0, 100, 200, 1'b0, 75, 0, "leak");
`else
        txn(0, 0, 0, 100, 200, 1'b0, 100, 0, "no_leak");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
